// File: rtl/tlk2711_pkg.sv
// Shared encodings and word patterns for the TLK2711 link controller.
package tlk2711_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_PWRUP  = 3'd1,
    ST_LOCK   = 3'd2,
    ST_SYNC   = 3'd3,
    ST_LINKED = 3'd4,
    ST_LOSS   = 3'd5
  } state_e;

  localparam logic [1:0] MODE_NORMAL = 2'd0;
  localparam logic [1:0] MODE_LOOP   = 2'd1;
  localparam logic [1:0] MODE_PRBS   = 2'd2;

  localparam logic [15:0] IDLE_WORD = 16'hC5BC;
  localparam logic [15:0] ERR_WORD  = 16'hFFFF;

  // One width shared by every timer and run counter, sized by the largest limit.
  function automatic int cnt_width(input int a, input int b, input int c,
                                   input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/tlk2711_link_ctrl_rx_mon.sv
// RX word classifier: consecutive IDLE / error run counters and saturating error total.
module tlk2711_rx_mon
  import tlk2711_pkg::*;
#(
  parameter int SYNC_CNT = 16,
  parameter int LOSS_CNT = 4,
  parameter int CNT_W    = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_sync_en,
  input  logic        i_link_en,
  input  logic        i_err_en,
  input  logic        i_err_clr,
  input  logic        i_rx_valid,
  input  logic [15:0] i_rxd,
  input  logic        i_rkmsb,
  input  logic        i_rklsb,
  output logic        o_sync_hit,
  output logic        o_loss_hit,
  output logic [15:0] o_err_cnt
);

  logic             w_is_idle;
  logic             w_is_err;
  logic [CNT_W-1:0] r_idle_run;
  logic [CNT_W-1:0] r_err_run;
  logic [15:0]      r_err_cnt;

  assign w_is_idle = i_rx_valid && (i_rxd == IDLE_WORD) && !i_rkmsb && i_rklsb;
  assign w_is_err  = i_rx_valid && (i_rxd == ERR_WORD) && i_rkmsb && i_rklsb;

  // Hits fire on the word that would bring the run up to its limit.
  assign o_sync_hit = i_sync_en && w_is_idle && (r_idle_run == CNT_W'(SYNC_CNT - 1));
  assign o_loss_hit = i_link_en && w_is_err && (r_err_run == CNT_W'(LOSS_CNT - 1));
  assign o_err_cnt  = r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_run <= '0;
      r_err_run  <= '0;
    end else if (i_clr) begin
      r_idle_run <= '0;
      r_err_run  <= '0;
    end else begin
      if (i_sync_en && i_rx_valid)
        r_idle_run <= w_is_idle ? r_idle_run + CNT_W'(1) : '0;
      if (i_link_en && i_rx_valid)
        r_err_run <= w_is_err ? r_err_run + CNT_W'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err_cnt <= '0;
    else if (i_err_clr)
      r_err_cnt <= '0;
    else if (i_err_en && w_is_err && (r_err_cnt != 16'hFFFF))
      r_err_cnt <= r_err_cnt + 16'd1;
  end

endmodule

// File: rtl/tlk2711_link_ctrl.sv
// TLK2711 channel bring-up / runtime controller: pin sequencing, TX mux, loss retry.
//   state  | meaning
//   OFF    | device disabled, pins low
//   PWRUP  | enabled, locking to reference clock
//   LOCK   | lckrefn high, sending IDLE while CDR locks to data
//   SYNC   | waiting for a run of RX IDLE words
//   LINKED | user TX words accepted, RX watched for errors
//   LOSS   | link dropped; re-lock to reference before retrying
module tlk2711_link_ctrl
  import tlk2711_pkg::*;
#(
  parameter int PWRUP_CYCLES   = 8000,
  parameter int LOCK_CYCLES    = 16000,
  parameter int SYNC_CNT       = 16,
  parameter int LOSS_CNT       = 4,
  parameter int TIMEOUT_CYCLES = 80000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic [1:0]  i_mode,
  input  logic [15:0] i_tx_data,
  input  logic [1:0]  i_tx_k,
  input  logic        i_tx_valid,
  output logic        o_tx_ready,
  input  logic        i_rx_valid,
  input  logic [15:0] i_2711_rxd,
  input  logic        i_2711_rkmsb,
  input  logic        i_2711_rklsb,
  output logic [15:0] o_2711_txd,
  output logic        o_2711_tkmsb,
  output logic        o_2711_tklsb,
  output logic        o_2711_enable,
  output logic        o_2711_lckrefn,
  output logic        o_2711_loopen,
  output logic        o_2711_prbsen,
  output logic        o_2711_testen,
  output logic [2:0]  o_state,
  output logic        o_linked,
  output logic        o_loss_irq,
  output logic [15:0] o_err_cnt
);

  localparam int CNT_W = cnt_width(PWRUP_CYCLES, LOCK_CYCLES, SYNC_CNT, LOSS_CNT, TIMEOUT_CYCLES);

  state_e           r_state, w_state_nxt;
  logic [1:0]       r_mode, w_mode_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_start_ok, w_xfer, w_clr, w_sync_hit, w_loss_hit;
  logic             w_enable, w_lckrefn, w_loopen, w_prbsen, w_linked, w_irq;
  logic [15:0]      w_txd;
  logic [1:0]       w_tk;
  logic [15:0]      r_txd;
  logic [1:0]       r_tk;
  logic             r_enable, r_lckrefn, r_loopen, r_prbsen, r_linked, r_irq;

  assign w_start_ok = (r_state == ST_OFF) && i_start && !i_stop;
  assign w_mode_nxt = !w_start_ok ? r_mode : ((i_mode == 2'd3) ? MODE_NORMAL : i_mode);
  assign w_clr      = (w_state_nxt != r_state);
  assign o_tx_ready = (r_state == ST_LINKED) && (r_mode != MODE_PRBS);
  assign w_xfer     = o_tx_ready && i_tx_valid;

  tlk2711_rx_mon #(
    .SYNC_CNT (SYNC_CNT),
    .LOSS_CNT (LOSS_CNT),
    .CNT_W    (CNT_W)
  ) u_rx_mon (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_clr),
    .i_sync_en  (r_state == ST_SYNC),
    .i_link_en  (r_state == ST_LINKED),
    .i_err_en   ((r_state == ST_SYNC) || (r_state == ST_LINKED) || (r_state == ST_LOSS)),
    .i_err_clr  (w_start_ok),
    .i_rx_valid (i_rx_valid),
    .i_rxd      (i_2711_rxd),
    .i_rkmsb    (i_2711_rkmsb),
    .i_rklsb    (i_2711_rklsb),
    .o_sync_hit (w_sync_hit),
    .o_loss_hit (w_loss_hit),
    .o_err_cnt  (o_err_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_OFF;
      r_mode  <= MODE_NORMAL;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      if (w_clr)
        r_cnt <= '0;
      else if ((r_state != ST_OFF) && (r_state != ST_LINKED))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_OFF:    if (w_start_ok) w_state_nxt = ST_PWRUP;
      ST_PWRUP:  if (r_cnt == CNT_W'(PWRUP_CYCLES - 1)) w_state_nxt = ST_LOCK;
      ST_LOCK:   if (r_cnt == CNT_W'(LOCK_CYCLES - 1)) w_state_nxt = ST_SYNC;
      ST_SYNC: begin
        if ((r_mode == MODE_PRBS) || w_sync_hit)
          w_state_nxt = ST_LINKED;
        else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1))
          w_state_nxt = ST_LOSS;
      end
      ST_LINKED: if (w_loss_hit) w_state_nxt = ST_LOSS;
      ST_LOSS:   if (r_cnt == CNT_W'(PWRUP_CYCLES - 1)) w_state_nxt = ST_LOCK;
      default:   w_state_nxt = ST_OFF;
    endcase
    // Stop beats everything, including a pending entry into LOSS.
    if (i_stop && (r_state != ST_OFF))
      w_state_nxt = ST_OFF;
  end

  // Pins are computed from the next state so they change together with o_state.
  always_comb begin
    w_enable  = (w_state_nxt != ST_OFF);
    w_lckrefn = (w_state_nxt == ST_LOCK) || (w_state_nxt == ST_SYNC) || (w_state_nxt == ST_LINKED);
    w_loopen  = (w_state_nxt != ST_OFF) && (w_mode_nxt == MODE_LOOP);
    w_prbsen  = (w_state_nxt != ST_OFF) && (w_mode_nxt == MODE_PRBS);
    w_linked  = (w_state_nxt == ST_LINKED);
    w_irq     = (w_state_nxt == ST_LOSS) && (r_state != ST_LOSS);
    w_txd     = IDLE_WORD;
    w_tk      = 2'b01;
    if (w_xfer) begin
      w_txd = i_tx_data;
      w_tk  = i_tx_k;
    end else if (w_state_nxt == ST_OFF) begin
      w_txd = '0;
      w_tk  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txd     <= '0;
      r_tk      <= '0;
      r_enable  <= 1'b0;
      r_lckrefn <= 1'b0;
      r_loopen  <= 1'b0;
      r_prbsen  <= 1'b0;
      r_linked  <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_txd     <= w_txd;
      r_tk      <= w_tk;
      r_enable  <= w_enable;
      r_lckrefn <= w_lckrefn;
      r_loopen  <= w_loopen;
      r_prbsen  <= w_prbsen;
      r_linked  <= w_linked;
      r_irq     <= w_irq;
    end
  end

  assign o_2711_txd     = r_txd;
  assign o_2711_tkmsb   = r_tk[1];
  assign o_2711_tklsb   = r_tk[0];
  assign o_2711_enable  = r_enable;
  assign o_2711_lckrefn = r_lckrefn;
  assign o_2711_loopen  = r_loopen;
  assign o_2711_prbsen  = r_prbsen;
  assign o_2711_testen  = 1'b0;
  assign o_state        = r_state;
  assign o_linked       = r_linked;
  assign o_loss_irq     = r_irq;

endmodule

// File: tb/tb_tlk2711_link_ctrl.sv
// Scoreboard bench for tlk2711_link_ctrl: a per-cycle reference model queues expected outputs.
module tb_tlk2711_link_ctrl;

  localparam int P_PWRUP = 8;
  localparam int P_LOCK  = 16;
  localparam int P_SYNC  = 4;
  localparam int P_LOSS  = 2;
  localparam int P_TMO   = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start, i_stop;
  logic [1:0]  i_mode;
  logic [15:0] i_tx_data;
  logic [1:0]  i_tx_k;
  logic        i_tx_valid, o_tx_ready;
  logic        i_rx_valid;
  logic [15:0] i_2711_rxd;
  logic        i_2711_rkmsb, i_2711_rklsb;
  logic [15:0] o_2711_txd;
  logic        o_2711_tkmsb, o_2711_tklsb;
  logic        o_2711_enable, o_2711_lckrefn, o_2711_loopen, o_2711_prbsen, o_2711_testen;
  logic [2:0]  o_state;
  logic        o_linked, o_loss_irq;
  logic [15:0] o_err_cnt;

  always #5 clk = ~clk;

  tlk2711_link_ctrl #(
    .PWRUP_CYCLES   (P_PWRUP),
    .LOCK_CYCLES    (P_LOCK),
    .SYNC_CNT       (P_SYNC),
    .LOSS_CNT       (P_LOSS),
    .TIMEOUT_CYCLES (P_TMO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start        (i_start),
    .i_stop         (i_stop),
    .i_mode         (i_mode),
    .i_tx_data      (i_tx_data),
    .i_tx_k         (i_tx_k),
    .i_tx_valid     (i_tx_valid),
    .o_tx_ready     (o_tx_ready),
    .i_rx_valid     (i_rx_valid),
    .i_2711_rxd     (i_2711_rxd),
    .i_2711_rkmsb   (i_2711_rkmsb),
    .i_2711_rklsb   (i_2711_rklsb),
    .o_2711_txd     (o_2711_txd),
    .o_2711_tkmsb   (o_2711_tkmsb),
    .o_2711_tklsb   (o_2711_tklsb),
    .o_2711_enable  (o_2711_enable),
    .o_2711_lckrefn (o_2711_lckrefn),
    .o_2711_loopen  (o_2711_loopen),
    .o_2711_prbsen  (o_2711_prbsen),
    .o_2711_testen  (o_2711_testen),
    .o_state        (o_state),
    .o_linked       (o_linked),
    .o_loss_irq     (o_loss_irq),
    .o_err_cnt      (o_err_cnt)
  );

  typedef struct packed {
    logic [2:0]  state;
    logic        linked;
    logic        irq;
    logic        ready;
    logic        en;
    logic        lck;
    logic        loop;
    logic        prbs;
    logic        test;
    logic [15:0] txd;
    logic [1:0]  tk;
    logic [15:0] err;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: link phase, time spent in it, current RX run length.
  int          m_state, m_elapsed, m_run, m_mode;
  logic [15:0] m_err;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cmp_all(input exp_t e);
    chk("state",   16'(o_state), 16'(e.state));
    chk("linked",  16'(o_linked), 16'(e.linked));
    chk("irq",     16'(o_loss_irq), 16'(e.irq));
    chk("ready",   16'(o_tx_ready), 16'(e.ready));
    chk("enable",  16'(o_2711_enable), 16'(e.en));
    chk("lckrefn", 16'(o_2711_lckrefn), 16'(e.lck));
    chk("loopen",  16'(o_2711_loopen), 16'(e.loop));
    chk("prbsen",  16'(o_2711_prbsen), 16'(e.prbs));
    chk("testen",  16'(o_2711_testen), 16'(e.test));
    chk("txd",     o_2711_txd, e.txd);
    chk("tk",      16'({o_2711_tkmsb, o_2711_tklsb}), 16'(e.tk));
    chk("err_cnt", o_err_cnt, e.err);
  endtask

  task automatic model_reset();
    m_state   = 0;
    m_elapsed = 0;
    m_run     = 0;
    m_mode    = 0;
    m_err     = '0;
  endtask

  task automatic model_step();
    bit   idle, err, xfer;
    int   nxt;
    exp_t e;
    idle = i_rx_valid && (i_2711_rxd == 16'hC5BC) && !i_2711_rkmsb && i_2711_rklsb;
    err  = i_rx_valid && (i_2711_rxd == 16'hFFFF) && i_2711_rkmsb && i_2711_rklsb;
    xfer = (m_state == 4) && (m_mode != 2) && i_tx_valid;
    nxt  = m_state;
    if (m_state >= 3 && err && m_err != 16'hFFFF) m_err = m_err + 16'd1;
    case (m_state)
      0: if (i_start && !i_stop) begin
           nxt    = 1;
           m_mode = (i_mode == 2'd3) ? 0 : int'(i_mode);
           m_err  = '0;
         end
      1: if (m_elapsed + 1 == P_PWRUP) nxt = 2;
      2: if (m_elapsed + 1 == P_LOCK) nxt = 3;
      3: if (m_mode == 2) nxt = 4;
         else begin
           if (idle) m_run++;
           else if (i_rx_valid) m_run = 0;
           if (m_run == P_SYNC) nxt = 4;
           else if (m_elapsed + 1 == P_TMO) nxt = 5;
         end
      4: begin
           if (err) m_run++;
           else if (i_rx_valid) m_run = 0;
           if (m_run == P_LOSS) nxt = 5;
         end
      5: if (m_elapsed + 1 == P_PWRUP) nxt = 2;
      default: ;
    endcase
    if (i_stop && m_state != 0) nxt = 0;
    e.irq = (nxt == 5) && (m_state != 5);
    if (nxt != m_state) begin
      m_elapsed = 0;
      m_run     = 0;
    end else begin
      m_elapsed++;
    end
    m_state  = nxt;
    e.state  = 3'(nxt);
    e.linked = (nxt == 4);
    e.ready  = (nxt == 4) && (m_mode != 2);
    e.en     = (nxt != 0);
    e.lck    = (nxt == 2) || (nxt == 3) || (nxt == 4);
    e.loop   = (nxt != 0) && (m_mode == 1);
    e.prbs   = (nxt != 0) && (m_mode == 2);
    e.test   = 1'b0;
    if (xfer) begin
      e.txd = i_tx_data;
      e.tk  = i_tx_k;
    end else if (nxt == 0) begin
      e.txd = 16'h0000;
      e.tk  = 2'b00;
    end else begin
      e.txd = 16'hC5BC;
      e.tk  = 2'b01;
    end
    e.err = m_err;
    sb_q.push_back(e);
  endtask

  // Monitor: every registered output update is compared with the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      cmp_all(e);
    end
  end

  task automatic cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    i_stop  = 1'b0;
  endtask

  // kind: 0 invalid, 1 IDLE, 2 error word, 3 random data
  task automatic rx_set(input int kind);
    i_rx_valid   = (kind != 0);
    i_2711_rxd   = 16'($urandom);
    i_2711_rkmsb = 1'($urandom);
    i_2711_rklsb = 1'($urandom);
    if (kind == 1) begin
      i_2711_rxd = 16'hC5BC; i_2711_rkmsb = 1'b0; i_2711_rklsb = 1'b1;
    end else if (kind == 2) begin
      i_2711_rxd = 16'hFFFF; i_2711_rkmsb = 1'b1; i_2711_rklsb = 1'b1;
    end
  endtask

  task automatic rx_bad();
    int r;
    r = $urandom_range(0, 2);
    rx_set(r == 0 ? 0 : (r == 1 ? 2 : 3));
  endtask

  task automatic bring_up(input logic [1:0] mode);
    i_mode  = mode;
    i_start = 1'b1;
    rx_set(1);
    cyc();
    for (int i = 0; i < 80 && m_state != 4; i++) begin
      i_mode = 2'($urandom);
      rx_set(1);
      cyc();
    end
  endtask

  initial begin
    exp_t zero;
    int   r;
    zero = '0;
    i_start = 0; i_stop = 0; i_mode = 0;
    i_tx_data = 0; i_tx_k = 0; i_tx_valid = 0;
    i_rx_valid = 0; i_2711_rxd = 0; i_2711_rkmsb = 0; i_2711_rklsb = 0;
    model_reset();
    repeat (3) @(negedge clk);
    cmp_all(zero);
    rst_n = 1'b1;
    @(negedge clk);

    bring_up(2'd0);
    repeat (2) begin rx_set(1); cyc(); end

    i_tx_valid = 1; i_tx_k = 2'b00;
    i_tx_data = 16'h1234; cyc();
    i_tx_data = 16'h5678; cyc();
    i_tx_valid = 0;
    repeat (3) cyc();
    for (int i = 0; i < 10; i++) begin
      i_tx_valid = 1'($urandom); i_tx_data = 16'($urandom); i_tx_k = 2'($urandom);
      cyc();
    end
    i_tx_valid = 0;

    rx_set(2); cyc();
    rx_set(1); cyc();
    rx_set(2); cyc();
    rx_set(2); cyc();
    for (int i = 0; i < 200 && !(m_state == 5 && m_elapsed > 3); i++) begin
      rx_bad();
      cyc();
    end

    i_stop = 1; rx_set(0); cyc();
    bring_up(2'd2);
    for (int i = 0; i < 6; i++) begin
      i_tx_valid = 1; i_tx_data = 16'($urandom); rx_set($urandom_range(0, 3)); cyc();
    end
    i_tx_valid = 0;
    i_stop = 1; cyc();
    bring_up(2'd1);
    i_stop = 1; cyc();
    bring_up(2'd3);
    rx_set(2); cyc();
    rx_set(2); i_stop = 1; cyc();
    rx_set(1); cyc(); cyc();
    i_start = 1; i_stop = 1; cyc();
    cyc();

    for (int i = 0; i < 3000; i++) begin
      i_start    = ($urandom_range(0, 49) == 0);
      i_stop     = ($urandom_range(0, 299) == 0);
      i_mode     = 2'($urandom);
      i_tx_valid = 1'($urandom);
      i_tx_data  = 16'($urandom);
      i_tx_k     = 2'($urandom);
      r = $urandom_range(0, 99);
      rx_set(r < 75 ? 1 : (r < 87 ? 2 : (r < 92 ? 3 : 0)));
      cyc();
    end
    i_tx_valid = 0;

    i_stop = 1; cyc();
    bring_up(2'd0);
    #2 rst_n = 1'b0;
    #1 cmp_all(zero);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    rx_set(1); cyc(); cyc();

    repeat (2) @(negedge clk);
    chk("sb_drain", 16'(sb_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tlk2711_link_ctrl.md
Name: tlk2711_link_ctrl

Overview:
Link-bring-up and runtime controller for one TLK2711 SerDes channel in the clk_80 domain.
- Sequences the device control pins (enable, lckrefn, loopen, prbsen, testen) through power-up, lock and sync.
- Transmits IDLE words until the link is up, then multiplexes user TX words onto the parallel bus.
- Monitors the RX word stream for sync and loss, raises an interrupt pulse on loss and retries automatically.
- Sits between the channel's TX/RX datapath and the TLK2711 pins; RX inputs are already re-timed into clk by the upstream RX FIFO.

Parameters:
PWRUP_CYCLES, 8000, cycles with enable=1, lckrefn=0 before lock phase (100 us at 80 MHz)
LOCK_CYCLES, 16000, cycles of IDLE transmission with lckrefn=1 before sync check
SYNC_CNT, 16, consecutive RX IDLE words required to declare link up
LOSS_CNT, 4, consecutive RX error words that declare loss
TIMEOUT_CYCLES, 80000, maximum cycles in SYNC before declaring loss

Ports:
clk  in  1  clock, 80 MHz
rst_n  in  1  asynchronous active-low reset
i_start  in  1  pulse; start bring-up (honoured only in OFF)
i_stop  in  1  pulse; return to OFF from any state
i_mode  in  2  0=normal, 1=loopback, 2=PRBS, 3=reserved (treated as 0); sampled on accepted i_start
i_tx_data  in  16  user TX word
i_tx_k  in  2  {msb,lsb} K-flags for i_tx_data
i_tx_valid  in  1  user word valid
o_tx_ready  out  1  user word accepted when valid&ready
i_rx_valid  in  1  RX word valid this cycle
i_2711_rxd  in  16  RX word
i_2711_rkmsb  in  1  RX K-flag, MSB
i_2711_rklsb  in  1  RX K-flag, LSB
o_2711_txd  out  16  TX word to device
o_2711_tkmsb  out  1  TX K-flag, MSB
o_2711_tklsb  out  1  TX K-flag, LSB
o_2711_enable  out  1  device enable
o_2711_lckrefn  out  1  0 = lock to reference clock
o_2711_loopen  out  1  internal loopback
o_2711_prbsen  out  1  PRBS generator/checker enable
o_2711_testen  out  1  device test enable; tied 0
o_state  out  3  current state encoding
o_linked  out  1  1 while in LINKED
o_loss_irq  out  1  one-cycle pulse on entry to LOSS
o_err_cnt  out  16  saturating count of RX error words; cleared on accepted i_start

Behaviour:
- Reset: all outputs 0. State = OFF. Mode register = 0. All counters = 0.
- IDLE word: txd=16'hC5BC, tklsb=1, tkmsb=0. RX IDLE match is the same pattern. RX error word: rkmsb=rklsb=1 and rxd=16'hFFFF.
- All pin outputs are registered.
- Pin settings: loopen = (mode==1) in every state except OFF. prbsen = (mode==2) in every state except OFF.
- States (o_state encoding):
  - OFF(0): enable=0, lckrefn=0, txd=0, tk=0. i_start → PWRUP.
  - PWRUP(1): enable=1, lckrefn=0, IDLE sent. After PWRUP_CYCLES → LOCK.
  - LOCK(2): lckrefn=1, IDLE sent. After LOCK_CYCLES → SYNC.
  - SYNC(3): IDLE sent.
    - Mode 2: → LINKED next cycle.
    - Otherwise: each valid IDLE match increments the consecutive counter; any other valid word clears it; invalid cycles hold it.
    - Counter reaches SYNC_CNT → LINKED. TIMEOUT_CYCLES elapsed in SYNC → LOSS.
  - LINKED(4): o_linked=1.
    - Each valid error word increments the consecutive-error counter; any valid non-error word clears it.
    - Counter reaches LOSS_CNT → LOSS.
  - LOSS(5): o_loss_irq=1 on the entry cycle only; lckrefn=0, IDLE sent. After PWRUP_CYCLES → LOCK (retry).
- Every state counter and consecutive counter clears on each state transition.
- i_stop in any state other than OFF → OFF next cycle. It overrides every other transition in that cycle, including one that would enter LOSS, so no irq is raised. Simultaneous i_start and i_stop in OFF: stay in OFF.
- i_start outside OFF is ignored. i_mode changes outside an accepted i_start are ignored.
- TX path:
  - o_tx_ready = (state==LINKED) && mode!=2, derived from the state register.
  - On valid&ready, o_2711_txd / tk register i_tx_data / i_tx_k with 1-cycle latency.
  - In LINKED with no transfer, IDLE is sent.
  - On the exit cycle from LINKED, ready has already been seen by the user, so that word is still transmitted.
- o_err_cnt: increments on every valid error word in SYNC/LINKED/LOSS, in all modes; saturates at 16'hFFFF.
- Counter widths: $clog2 of the largest parameter + 1.

Decomposition:
- Package tlk2711_pkg:
  - state encodings OFF..LOSS
  - mode codes MODE_NORMAL/LOOP/PRBS
  - IDLE_WORD=16'hC5BC
  - ERR_WORD=16'hFFFF
- Sub-module tlk2711_rx_mon:
  - classifies each valid RX word as IDLE or error
  - owns the consecutive-IDLE and consecutive-error counters, with a clear input from the FSM
  - owns the saturating o_err_cnt

Test Plan:
Bench parameters: PWRUP=8, LOCK=16, SYNC_CNT=4, LOSS_CNT=2, TIMEOUT=64.
1. Reset then i_start with mode 0; feed continuous RX IDLE → enable rises 1 cycle after start, lckrefn rises 8 cycles later, o_linked=1 after 16 lock cycles + 4 IDLE words; txd=C5BC throughout.
2. LINKED; push words 16'h1234 then 16'h5678 with valid → appear on o_2711_txd one cycle after each transfer, tk=00; IDLE resumes after the last word.
3. LINKED; RX error word, then a good word, then error, error → no loss after the first error; o_loss_irq 1-cycle pulse after the 2nd consecutive error; o_err_cnt=3; LOCK re-entered 8 cycles later.
4. SYNC with RX never IDLE → LOSS after exactly 64 cycles in SYNC, one irq pulse.
5. i_start mode 2 → prbsen=1, LINKED right after LOCK, o_tx_ready=0; mode 1 → loopen=1.
6. i_stop in the cycle the 2nd error arrives → OFF next cycle, no irq, all pins 0. Assert rst_n mid-LINKED → all outputs 0 asynchronously.
